// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter (8N1, optionally 8E1) fed by a small byte FIFO.
//
// Bytes written on a one-cycle wr_en strobe are queued and then sent LSB-first
// on tx. Each bit lasts CLKS_PER_BIT clocks. When the stop bit of one frame
// ends and another byte is waiting, the next start bit follows with no idle gap.
//
// Optional feature: define UART_TX_PARITY_EN to add an even-parity bit between
// the data bits and the stop bit. This makes each frame 11 bit times long
// instead of 10.
//
// Ports:
//   clk      in   system clock, rising edge
//   Rst      in   synchronous reset, active-high
//   wr_en    in   write strobe; pushes wr_data when not full
//   wr_data  in   byte to transmit
//   full     out  FIFO holds FIFO_DEPTH bytes
//   empty    out  FIFO holds 0 bytes
//   count    out  FIFO occupancy, 0..FIFO_DEPTH
//   busy     out  serialiser is not idle
//   overflow out  sticky: a write was dropped because the FIFO was full
//   tx       out  serial line, idles high
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             overflow,
    output logic             tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity: the XOR of all eight data bits.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             overflow_r;

    state_t           state_r,   state_nxt_s;
    logic [TMR_W-1:0] timer_r,   timer_nxt_s;
    logic [2:0]       bit_idx_r, bit_idx_nxt_s;
    logic [7:0]       shift_r,   shift_nxt_s;
    logic             tx_r,      tx_nxt_s;
`ifdef UART_TX_PARITY_EN
    logic             parity_r,  parity_nxt_s;
`endif

    logic full_s, empty_s, push_s, pop_s, bit_end_s;

    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty_s   = (count_r == CNT_W'(0));
    assign push_s    = wr_en & ~full_s;
    assign bit_end_s = (timer_r == TMR_W'(CLKS_PER_BIT - 1));

    // Serialiser next-state logic. tx_nxt_s holds the level for the cycle after
    // the edge, so that tx can come straight from a register.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        tx_nxt_s      = tx_r;
        pop_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                tx_nxt_s    = 1'b1;
                timer_nxt_s = TMR_W'(0);
                if (!empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = mem_r[rd_ptr_r];
                    state_nxt_s = ST_START;
                    tx_nxt_s    = 1'b0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    timer_nxt_s   = TMR_W'(0);
                    bit_idx_nxt_s = 3'd0;
                    state_nxt_s   = ST_DATA;
                    tx_nxt_s      = shift_r[0];
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    timer_nxt_s = TMR_W'(0);
                    if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt_s = ST_PARITY;
                        tx_nxt_s    = parity_r;
`else
                        state_nxt_s = ST_STOP;
                        tx_nxt_s    = 1'b1;
`endif
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                        shift_nxt_s   = {1'b0, shift_r[7:1]};
                        tx_nxt_s      = shift_r[1];
                    end
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    timer_nxt_s = TMR_W'(0);
                    state_nxt_s = ST_STOP;
                    tx_nxt_s    = 1'b1;
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (bit_end_s) begin
                    timer_nxt_s = TMR_W'(0);
                    if (!empty_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = mem_r[rd_ptr_r];
                        state_nxt_s = ST_START;
                        tx_nxt_s    = 1'b0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        tx_nxt_s    = 1'b1;
                    end
                end else begin
                    timer_nxt_s = timer_r + TMR_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                timer_nxt_s = TMR_W'(0);
                tx_nxt_s    = 1'b1;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    // Parity is captured at pop time because the shift register is consumed
    // while the data bits are sent.
    always_comb begin
        if (pop_s) begin
            parity_nxt_s = even_parity(mem_r[rd_ptr_r]);
        end else begin
            parity_nxt_s = parity_r;
        end
    end
`endif

    // Serialiser state registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_r   <= ST_IDLE;
            timer_r   <= TMR_W'(0);
            bit_idx_r <= 3'd0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
`ifdef UART_TX_PARITY_EN
            parity_r  <= parity_nxt_s;
`endif
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag. A write while
    // full is dropped even when a pop frees a slot at the same edge.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr_r   <= PTR_W'(0);
            rd_ptr_r   <= PTR_W'(0);
            count_r    <= CNT_W'(0);
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            overflow_r <= overflow_r | (wr_en & full_s);
        end
    end

    // FIFO storage. Its contents need no reset because the pointers define
    // which entries are valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign full     = full_s;
    assign empty    = empty_s;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign busy     = (state_r != ST_IDLE);
    assign tx       = tx_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A UART receiver model samples tx at each bit centre and queues the raw frame
// bits (bit i = i-th bit on the line). Directed tests compare those frames,
// and the status outputs, against hand-computed constants.
module tb_uart_tx_fifo;

    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic          clk = 1'b0;
    logic          Rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full, empty, busy, overflow, tx;
    logic [CW-1:0] count;

    uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .Rst(Rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .busy(busy),
        .overflow(overflow), .tx(tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Status word: {tx, busy, empty, full, overflow, count[2:0]}.
    function automatic logic [7:0] status();
        return {tx, busy, empty, full, overflow, count};
    endfunction

    // Receiver model. Frames cut short by a reset are discarded.
    logic [10:0] rx_q [$];
    int rst_cnt = 0;
    always @(posedge clk) if (Rst) rst_cnt++;

    initial begin
        logic [10:0] bits;
        int rc;
        forever begin
            @(negedge clk);
            if (Rst === 1'b0 && tx === 1'b0) begin
                bits = 11'd0;
                rc   = rst_cnt;
                for (int i = 0; i < FB; i++) begin
                    repeat ((i == 0) ? 2 : C) @(negedge clk);
                    bits[i] = tx;
                end
                if (rc == rst_cnt) rx_q.push_back(bits);
            end
        end
    end

    // Steps until busy drops and returns the number of cycles counted.
    // Running out of the cycle budget counts as a failure.
    task automatic busy_run(output int n);
        n = 0;
        while (busy && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [7:0]  data;
        logic [10:0] exp_bits;
    } vec_t;

    vec_t vecs [6];
    logic [10:0] ovf_exp [5];
    logic [CW-1:0] ovf_cnt [6];
    logic          ovf_flg [6];

    initial begin
        int n;
        logic [10:0] got;

`ifdef UART_TX_PARITY_EN
        vecs[0] = '{8'h55, 11'h4AA};
        vecs[1] = '{8'h07, 11'h60E};
        vecs[2] = '{8'h00, 11'h400};
        vecs[3] = '{8'hFF, 11'h5FE};
        vecs[4] = '{8'hA3, 11'h546};
        vecs[5] = '{8'h0F, 11'h41E};
        ovf_exp = '{11'h602, 11'h604, 11'h406, 11'h608, 11'h40A};
`else
        vecs[0] = '{8'h55, 11'h2AA};
        vecs[1] = '{8'h07, 11'h20E};
        vecs[2] = '{8'h00, 11'h200};
        vecs[3] = '{8'hFF, 11'h3FE};
        vecs[4] = '{8'hA3, 11'h346};
        vecs[5] = '{8'h0F, 11'h21E};
        ovf_exp = '{11'h202, 11'h204, 11'h206, 11'h208, 11'h20A};
`endif
        ovf_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
        ovf_flg = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset and idle.
        Rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
        step();
        chk("reset_state", {24'd0, status()}, 32'h0000_00A0);
        step();
        Rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_state", {24'd0, status()}, 32'h0000_00A0);
        end

        // Single frames: latency, frame length and bit pattern.
        for (int v = 0; v < 6; v++) begin
            wr_en = 1'b1; wr_data = vecs[v].data;
            step();
            wr_en = 1'b0;
            chk("push_status", {28'd0, tx, empty, count}, {28'd0, 1'b1, 1'b0, 3'd1});
            step();
            chk("pop_start", {29'd0, tx, busy, empty}, {29'd0, 1'b0, 1'b1, 1'b1});
            busy_run(n);
            chk("frame_len", n, FB * C);
            chk("frame_end_tx", {31'd0, tx}, 32'd1);
            step(); step();
            chk("rx_count", rx_q.size(), 32'd1);
            if (rx_q.size() > 0) begin
                got = rx_q.pop_front();
                chk("frame_bits", {21'd0, got}, {21'd0, vecs[v].exp_bits});
            end
            rx_q.delete();
        end

        // Back-to-back frames: busy never drops between the two frames.
        wr_en = 1'b1; wr_data = 8'hA3;
        step();
        wr_data = 8'h0F;
        step();
        wr_en = 1'b0;
        busy_run(n);
        chk("b2b_len", n, 2 * FB * C);
        step(); step();
        chk("b2b_rx_count", rx_q.size(), 32'd2);
        if (rx_q.size() == 2) begin
            chk("b2b_frame0", {21'd0, rx_q[0]}, {21'd0, vecs[4].exp_bits});
            chk("b2b_frame1", {21'd0, rx_q[1]}, {21'd0, vecs[5].exp_bits});
        end
        rx_q.delete();

        // Overflow: 0x01..0x06 on consecutive cycles; 0x06 is dropped.
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            step();
            chk("ovf_count", {29'd0, count}, {29'd0, ovf_cnt[i]});
            chk("ovf_flags", {30'd0, full, overflow},
                {30'd0, (ovf_cnt[i] == 3'd4), ovf_flg[i]});
        end
        wr_en = 1'b0;
        n = 0;
        while ((busy || !empty) && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk("ovf_drain_timeout", 32'd1, 32'd0);
        step(); step();
        chk("ovf_sticky", {28'd0, overflow, count}, {28'd0, 1'b1, 3'd0});
        chk("ovf_rx_count", rx_q.size(), 32'd5);
        if (rx_q.size() == 5) begin
            for (int i = 0; i < 5; i++)
                chk("ovf_frame", {21'd0, rx_q[i]}, {21'd0, ovf_exp[i]});
        end
        rx_q.delete();

        // Reset in the middle of the data bits with two bytes queued.
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 8'h11 * 8'(i + 1);
            step();
        end
        wr_en = 1'b0;
        repeat (6) step();
        chk("pre_rst", {28'd0, busy, count}, {28'd0, 1'b1, 3'd2});
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        chk("mid_rst_state", {24'd0, status()}, 32'h0000_00A0);
        for (int i = 0; i < 100; i++) begin
            step();
            chk("post_rst_idle", {24'd0, status()}, 32'h0000_00A0);
        end
        chk("post_rst_rx", rx_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
